// File: rtl/vga_timing_engine.sv
// vga_timing_engine
//   Parametrised VGA raster engine. It generates hsync, vsync and n_blank, and a
//   frame-buffer read address for a movable, integer-scaled image window. Sync
//   and blank are delayed by the memory read latency, so they stay aligned with
//   the pixel data that comes back.
// Ports
//   clock_25     pixel clock; all logic runs on the rising edge
//   reset        asynchronous, active-low
//   start        pulse: begin or continue scanning
//   stop         pulse: finish the current frame, then go idle
//   win_x0/y0    window top-left corner in screen pixels/lines (sampled at frame start)
//   address      frame-buffer read address (undelayed)
//   pixel_x/y    screen coordinates of the delayed stream
//   hsync/vsync  delayed sync outputs
//   n_blank      delayed; 1 = visible area
//   in_window    delayed; 1 = pixel is inside the scaled image window
//   frame_start  delayed one-cycle pulse at x=0, y=0
//   running      undelayed; 1 while scanning (not idle)
module vga_timing_engine #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter bit          HS_POL     = 1'b0,
    parameter bit          VS_POL     = 1'b0,
    parameter int unsigned IMG_W      = 160,
    parameter int unsigned IMG_H      = 120,
    parameter int unsigned SCALE_LOG2 = 1,
    parameter int unsigned ADDR_W     = 18,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic              clock_25,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [9:0]        win_x0,
    input  logic [9:0]        win_y0,
    output logic [ADDR_W-1:0] address,
    output logic [9:0]        pixel_x,
    output logic [9:0]        pixel_y,
    output logic              hsync,
    output logic              vsync,
    output logic              n_blank,
    output logic              in_window,
    output logic              frame_start,
    output logic              running
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_ACT_C  = 12'(H_ACTIVE);
    localparam logic [11:0] H_LAST_C = 12'(H_TOTAL - 1);
    localparam logic [11:0] HS_BEG_C = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END_C = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] V_ACT_C  = 12'(V_ACTIVE);
    localparam logic [11:0] V_LAST_C = 12'(V_TOTAL - 1);
    localparam logic [11:0] VS_BEG_C = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END_C = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] WIN_W_C  = 12'(IMG_W << SCALE_LOG2);
    localparam logic [11:0] WIN_H_C  = 12'(IMG_H << SCALE_LOG2);

    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);
    localparam int unsigned       SUB_W    = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;
    localparam logic [SUB_W-1:0]  SUB_MAX  = SUB_W'((1 << SCALE_LOG2) - 1);

    // Timing vector: {hsync, vsync, n_blank, in_window, frame_start, x[9:0], y[9:0]}
    localparam int unsigned     TV_W    = 25;
    localparam logic [TV_W-1:0] TV_IDLE = {~HS_POL, ~VS_POL, 23'd0};

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STOPPING} state_t;

    state_t            r_state, w_state_nx;
    logic [11:0]       r_h, r_v;
    logic [9:0]        r_wx, r_wy;
    logic [ADDR_W-1:0] r_addr, r_row_base;
    logic [SUB_W-1:0]  r_subx, r_suby;

    logic              w_run, w_h_last, w_v_last, w_enter_idle;
    logic [11:0]       w_wx, w_wy, w_x_end_raw, w_y_end_raw, w_x_end, w_y_end;
    logic [11:0]       w_h_nx1, w_v_nx1;
    logic              w_row_in, w_nrow_in, w_in_win, w_active, w_hs, w_vs, w_fs;
    logic [ADDR_W-1:0] w_row_nx;
    logic [TV_W-1:0]   w_tv, w_tv_out;

    assign w_run    = (r_state != ST_IDLE);
    assign w_h_last = (r_h == H_LAST_C);
    assign w_v_last = (r_v == V_LAST_C);
    assign w_h_nx1  = r_h + 12'd1;
    assign w_v_nx1  = r_v + 12'd1;

    // Window bounds, clipped to the active area (12-bit math, so there is no wrap)
    assign w_wx        = {2'b00, r_wx};
    assign w_wy        = {2'b00, r_wy};
    assign w_x_end_raw = w_wx + WIN_W_C;
    assign w_y_end_raw = w_wy + WIN_H_C;
    assign w_x_end     = (w_x_end_raw > H_ACT_C) ? H_ACT_C : w_x_end_raw;
    assign w_y_end     = (w_y_end_raw > V_ACT_C) ? V_ACT_C : w_y_end_raw;

    assign w_row_in  = (r_v >= w_wy) && (r_v < w_y_end);
    assign w_nrow_in = (w_v_nx1 >= w_wy) && (w_v_nx1 < w_y_end);
    assign w_in_win  = w_run && w_row_in && (r_h >= w_wx) && (r_h < w_x_end);
    assign w_row_nx  = (w_row_in && (r_suby == SUB_MAX)) ? r_row_base + ROW_STEP : r_row_base;

    assign w_active = w_run && (r_h < H_ACT_C) && (r_v < V_ACT_C);
    assign w_hs     = ((r_h >= HS_BEG_C) && (r_h < HS_END_C)) ? HS_POL : ~HS_POL;
    assign w_vs     = ((r_v >= VS_BEG_C) && (r_v < VS_END_C)) ? VS_POL : ~VS_POL;
    assign w_fs     = w_run && (r_h == 12'd0) && (r_v == 12'd0);
    assign w_tv     = w_run ? {w_hs, w_vs, w_active, w_in_win, w_fs, r_h[9:0], r_v[9:0]}
                            : TV_IDLE;

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE:     if (start) w_state_nx = ST_RUN;
            ST_RUN:      if (stop && !start) w_state_nx = ST_STOPPING;
            ST_STOPPING: begin
                if (start) w_state_nx = ST_RUN;
                else if (w_h_last && w_v_last) w_state_nx = ST_IDLE;
            end
            default:     w_state_nx = ST_IDLE;
        endcase
    end

    assign w_enter_idle = w_run && (w_state_nx == ST_IDLE);

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nx;
    end

    // Window corner is loaded on the edge into pixel (0,0), so that pixel
    // already uses the new window; while idle the counters sit at (0,0).
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            r_wx <= '0;
            r_wy <= '0;
        end else if (!w_run || (w_h_last && w_v_last)) begin
            r_wx <= win_x0;
            r_wy <= win_y0;
        end
    end

    // Raster counters and incremental address. The address moves to the next
    // source pixel only if the following screen pixel is still in the window,
    // so it holds its last in-window value outside the window.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            r_h        <= '0;
            r_v        <= '0;
            r_addr     <= '0;
            r_row_base <= '0;
            r_subx     <= '0;
            r_suby     <= '0;
        end else if (!w_run) begin
            r_h        <= '0;
            r_v        <= '0;
            r_addr     <= '0;
            r_row_base <= '0;
            r_subx     <= '0;
            r_suby     <= '0;
        end else if (w_h_last) begin
            r_h    <= '0;
            r_subx <= '0;
            if (w_v_last) begin
                r_v        <= '0;
                r_addr     <= '0;
                r_row_base <= '0;
                r_suby     <= '0;
            end else begin
                r_v        <= w_v_nx1;
                r_row_base <= w_row_nx;
                if (w_row_in) r_suby <= (r_suby == SUB_MAX) ? '0 : r_suby + 1'b1;
                if (w_nrow_in) r_addr <= w_row_nx;
            end
        end else begin
            r_h <= w_h_nx1;
            if (w_in_win) begin
                if (r_subx == SUB_MAX) begin
                    r_subx <= '0;
                    if (w_h_nx1 < w_x_end) r_addr <= r_addr + 1'b1;
                end else begin
                    r_subx <= r_subx + 1'b1;
                end
            end
        end
    end

    generate
        if (RD_LAT == 0) begin : g_nolat
            assign w_tv_out = w_tv;
        end else begin : g_lat
            logic [TV_W-1:0] r_pipe [RD_LAT];
            always_ff @(posedge clock_25 or negedge reset) begin
                if (!reset || w_enter_idle) begin
                    for (int unsigned i = 0; i < RD_LAT; i++) r_pipe[i] <= TV_IDLE;
                end else begin
                    r_pipe[0] <= w_tv;
                    for (int unsigned i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
                end
            end
            assign w_tv_out = r_pipe[RD_LAT-1];
        end
    endgenerate

    assign {hsync, vsync, n_blank, in_window, frame_start, pixel_x, pixel_y} = w_tv_out;
    assign address = r_addr;
    assign running = w_run;

endmodule

// File: tb/tb_vga_timing_engine.sv
// tb_vga_timing_engine
//   Three engines share clock, reset, start/stop and window inputs:
//   u_def  - default 640x480 timing, RD_LAT=1 (first line only)
//   u_l0   - small raster 20+2+3+3 x 12+1+2+1 (28x16), 4x3 image, S=1, RD_LAT=0
//   u_l3   - same small raster with RD_LAT=3
//   k counts clocks from the edge that samples start (k=0: h=v=0 undelayed).
module tb_vga_timing_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, stop;
    logic [9:0] win_x0, win_y0;

    logic [17:0] d_addr;
    logic [9:0]  d_px, d_py;
    logic        d_hs, d_vs, d_nb, d_iw, d_fs, d_run;
    logic [7:0]  a_addr;
    logic [9:0]  a_px, a_py;
    logic        a_hs, a_vs, a_nb, a_iw, a_fs, a_run;
    logic [7:0]  b_addr;
    logic [9:0]  b_px, b_py;
    logic        b_hs, b_vs, b_nb, b_iw, b_fs, b_run;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    vga_timing_engine u_def (
        .clock_25(clk), .reset(rst_n), .start(start), .stop(stop),
        .win_x0(win_x0), .win_y0(win_y0), .address(d_addr),
        .pixel_x(d_px), .pixel_y(d_py), .hsync(d_hs), .vsync(d_vs),
        .n_blank(d_nb), .in_window(d_iw), .frame_start(d_fs), .running(d_run)
    );

    vga_timing_engine #(
        .H_ACTIVE(20), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .IMG_W(4), .IMG_H(3), .SCALE_LOG2(1), .ADDR_W(8), .RD_LAT(0)
    ) u_l0 (
        .clock_25(clk), .reset(rst_n), .start(start), .stop(stop),
        .win_x0(win_x0), .win_y0(win_y0), .address(a_addr),
        .pixel_x(a_px), .pixel_y(a_py), .hsync(a_hs), .vsync(a_vs),
        .n_blank(a_nb), .in_window(a_iw), .frame_start(a_fs), .running(a_run)
    );

    vga_timing_engine #(
        .H_ACTIVE(20), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .IMG_W(4), .IMG_H(3), .SCALE_LOG2(1), .ADDR_W(8), .RD_LAT(3)
    ) u_l3 (
        .clock_25(clk), .reset(rst_n), .start(start), .stop(stop),
        .win_x0(win_x0), .win_y0(win_y0), .address(b_addr),
        .pixel_x(b_px), .pixel_y(b_py), .hsync(b_hs), .vsync(b_vs),
        .n_blank(b_nb), .in_window(b_iw), .frame_start(b_fs), .running(b_run)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int d_nb_first = -1, a_nb_first = -1, b_nb_first = -1;
    int d_hs_first = -1, d_hs_cnt = 0;
    int a_fs_cnt = 0, a_vs_cnt = 0;
    int win1_cnt = 0, win1_first = -1, win1_last = -1, win3_cnt = 0;

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        stop   = 1'b0;
        win_x0 = 10'd5;
        win_y0 = 10'd3;
        repeat (3) step();

        chk("rst_hsync",  d_hs, 1);
        chk("rst_vsync",  d_vs, 1);
        chk("rst_nblank", d_nb, 0);
        chk("rst_inwin",  d_iw, 0);
        chk("rst_fstart", d_fs, 0);
        chk("rst_run",    d_run, 0);
        chk("rst_px",     d_px, 0);
        chk("rst_py",     d_py, 0);
        chk("rst_addr",   d_addr, 0);

        rst_n = 1'b1;
        repeat (3) step();
        chk("idle_run",    d_run, 0);
        chk("idle_nblank", d_nb, 0);
        chk("idle_l0_nb",  a_nb, 0);
        chk("idle_l0_hs",  a_hs, 1);

        start = 1'b1;
        for (int k = 0; k <= 2700; k++) begin
            step();

            if (d_nb && d_nb_first < 0) d_nb_first = k;
            if (a_nb && a_nb_first < 0) a_nb_first = k;
            if (b_nb && b_nb_first < 0) b_nb_first = k;
            if (k < 1000 && !d_hs) begin
                if (d_hs_first < 0) d_hs_first = k;
                d_hs_cnt++;
            end
            if (k < 896 && a_fs) a_fs_cnt++;
            if (k < 896 && !a_vs) a_vs_cnt++;
            if (k < 448 && a_iw) begin
                if (win1_first < 0) win1_first = k;
                win1_last = k;
                win1_cnt++;
            end
            if (k >= 896 && k < 1344 && a_iw) win3_cnt++;

            case (k)
                0:    begin chk("k0_fs", a_fs, 1); chk("k0_run", a_run, 1); end
                88:   begin chk("x4y3_iw", a_iw, 0); chk("x4y3_addr", a_addr, 0); end
                89:   begin chk("x5y3_iw", a_iw, 1); chk("x5y3_addr", a_addr, 0); chk("l3_addr_x5", b_addr, 0); end
                90:   chk("x6y3_addr", a_addr, 0);
                91:   begin chk("x7y3_addr", a_addr, 1); chk("l3_iw_early", b_iw, 0); end
                92:   begin chk("l3_iw_lat", b_iw, 1); chk("l3_px_lat", b_px, 5); end
                96:   begin chk("x12y3_addr", a_addr, 3); chk("x12y3_iw", a_iw, 1); end
                97:   begin chk("x13y3_addr", a_addr, 3); chk("x13y3_iw", a_iw, 0); end
                117:  chk("x5y4_addr", a_addr, 0);
                145:  chk("x5y5_addr", a_addr, 4);
                235:  chk("x11y8_addr", a_addr, 11);
                236:  chk("x12y8_addr", a_addr, 11);
                280:  chk("x0y10_addr", a_addr, 11);
                448:  begin chk("f2_fs", a_fs, 1); chk("f2_addr", a_addr, 0); end
                537:  chk("f2_old_win_in", a_iw, 1);
                548:  chk("f2_new_win_out", a_iw, 0);
                985:  chk("f3_old_win_out", a_iw, 0);
                996:  begin chk("f3_x16_iw", a_iw, 1); chk("f3_x16_addr", a_addr, 0); end
                999:  begin chk("f3_x19_iw", a_iw, 1); chk("f3_x19_addr", a_addr, 1); end
                1000: chk("f3_clip_x20", a_iw, 0);
                1008: chk("f3_nowrap_x0", a_iw, 0);
                1791: chk("stop_last_run", a_run, 1);
                1792: begin
                    chk("stop_run",   a_run, 0);
                    chk("stop_nb",    a_nb, 0);
                    chk("stop_hs",    a_hs, 1);
                    chk("stop_vs",    a_vs, 1);
                    chk("stop_fs",    a_fs, 0);
                    chk("stop_l3_px", b_px, 0);
                    chk("stop_l3_py", b_py, 0);
                    chk("stop_l3_hs", b_hs, 1);
                end
                1795: chk("idle_addr", a_addr, 0);
                1801: begin chk("rs_fs", a_fs, 1); chk("rs_run", a_run, 1); end
                2000: chk("stopping_run", a_run, 1);
                2249: begin chk("cancel_run", a_run, 1); chk("cancel_fs", a_fs, 1); chk("cancel_nb", a_nb, 1); end
                2697: begin chk("both_run", a_run, 1); chk("both_fs", a_fs, 1); end
                2700: chk("pre_rst_nb", a_nb, 1);
                default: ;
            endcase

            start  = (k == 1800) || (k == 2081) || (k == 2277);
            stop   = (k == 1512) || (k == 1969) || (k == 2277);
            win_x0 = (k >= 498) ? 10'd16 : 10'd5;
        end

        chk("def_nb_rise",  d_nb_first, 1);
        chk("l0_nb_rise",   a_nb_first, 0);
        chk("l3_nb_rise",   b_nb_first, 3);
        chk("def_hs_start", d_hs_first, 657);
        chk("def_hs_width", d_hs_cnt, 96);
        chk("l0_fs_count",  a_fs_cnt, 2);
        chk("l0_vs_low",    a_vs_cnt, 112);
        chk("f1_win_cnt",   win1_cnt, 48);
        chk("f1_win_first", win1_first, 89);
        chk("f1_win_last",  win1_last, 236);
        chk("f3_win_cnt",   win3_cnt, 24);

        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_l0_nb",   a_nb, 0);
        chk("arst_l0_run",  a_run, 0);
        chk("arst_l0_px",   a_px, 0);
        chk("arst_l0_addr", a_addr, 0);
        chk("arst_def_run", d_run, 0);
        chk("arst_def_hs",  d_hs, 1);
        chk("arst_l3_nb",   b_nb, 0);
        chk("arst_l3_px",   b_px, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
